// File: rtl/queue_occupancy_counter.sv
// Debounces entrance/exit photocells into a bounded people count, registers the
// teller switches, and pulses rom_enable whenever the ROM address inputs change.
module queue_occupancy_counter #(
    parameter int DEB_CYCLES = 4,
    parameter int MAX_PEOPLE = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       front_sensor,
    input  logic       back_sensor,
    input  logic [1:0] tcount_in,
    output logic [2:0] pcount,
    output logic [1:0] tcount,
    output logic       rom_enable,
    output logic       full,
    output logic       empty,
    output logic       reject
);

    localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);
    localparam logic [2:0] MAX_P    = 3'(MAX_PEOPLE);

    // Index 0 is the entrance sensor, index 1 the exit sensor.
    logic [1:0] raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] st;
    logic [1:0] st_d;
    logic [1:0] tsync1;
    logic [1:0] tsync2;
    logic       init_done;

    assign raw = {back_sensor, front_sensor};

    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic [3:0] cnt;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync1[i] <= 1'b0;
                sync2[i] <= 1'b0;
                st[i]    <= 1'b0;
                st_d[i]  <= 1'b0;
                cnt      <= 4'd0;
            end else begin
                sync1[i] <= raw[i];
                sync2[i] <= sync1[i];
                st_d[i]  <= st[i];
                if (sync2[i] == st[i]) begin
                    cnt <= 4'd0;
                end else if (cnt < DEB_LAST) begin
                    cnt <= cnt + 4'd1;
                end else begin
                    st[i] <= sync2[i];
                    cnt   <= 4'd0;
                end
            end
        end
    end

    logic       enter_evt;
    logic       exit_evt;
    logic [2:0] pcount_nxt;
    logic       reject_nxt;

    assign enter_evt = st[0] & ~st_d[0];
    assign exit_evt  = st[1] & ~st_d[1];

    // Simultaneous entry and exit cancel out with no reject, even at the bounds.
    always_comb begin
        pcount_nxt = pcount;
        reject_nxt = 1'b0;
        if (enter_evt && !exit_evt) begin
            if (pcount < MAX_P) pcount_nxt = pcount + 3'd1;
            else                reject_nxt = 1'b1;
        end else if (exit_evt && !enter_evt) begin
            if (pcount != 3'd0 && tcount != 2'd0) pcount_nxt = pcount - 3'd1;
            else                                   reject_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tsync1     <= 2'd0;
            tsync2     <= 2'd0;
            tcount     <= 2'd0;
            pcount     <= 3'd0;
            full       <= 1'b0;
            empty      <= 1'b1;
            reject     <= 1'b0;
            rom_enable <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            tsync1     <= tcount_in;
            tsync2     <= tsync1;
            tcount     <= tsync2;
            pcount     <= pcount_nxt;
            full       <= (pcount_nxt == MAX_P);
            empty      <= (pcount_nxt == 3'd0);
            reject     <= reject_nxt;
            // First edge out of reset forces a ROM load so Wtime is valid.
            rom_enable <= !init_done || (pcount_nxt != pcount) || (tsync2 != tcount);
            init_done  <= 1'b1;
        end
    end

endmodule
